// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the digit-serial BCD subtractor.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    RECOMP,
    DONE
  } state_t;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/Complement_9.sv
// Single BCD digit 9's complement: c = 9 - d for d in 0..9.
module Complement_9
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] comp
);

  always_comb begin
    comp = BCD_MAX - digit;
  end

endmodule

// File: rtl/bcd_digit_adder.sv
// Combinational BCD digit adder: x + y + cin, decimal-corrected, with carry out.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] x,
  input  logic [BCD_DIGIT_W-1:0] y,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   cout
);

  logic [BCD_DIGIT_W:0] raw;

  always_comb begin
    raw = {1'b0, x} + {1'b0, y} + {{BCD_DIGIT_W{1'b0}}, cin};
    if (raw > {1'b0, BCD_MAX}) begin
      digit = BCD_DIGIT_W'(raw - 5'd10);
      cout  = 1'b1;
    end else begin
      digit = raw[BCD_DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_sub_sequencer.sv
// Digit-serial N-digit BCD subtractor: |A - B| and sign, via 10's complement add
// with an optional re-complement pass, sharing one complementer and one adder.
module bcd_sub_sequencer
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  negative,
  output logic                  invalid
);

  localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = $clog2(DIGITS) + 1;

  state_t                 state, state_nx;
  logic [W-1:0]           a_q, b_q;
  logic [IDX_W-1:0]       idx;
  logic                   carry;
  logic                   last;
  logic                   ops_valid;
  logic [BCD_DIGIT_W-1:0] a_dig, b_dig, r_dig;
  logic [BCD_DIGIT_W-1:0] comp_in, comp_out, add_x, sum_dig;
  logic                   sum_cout;

  // Compare-and-select instead of variable part-selects keeps the index
  // range provably in bounds for any DIGITS.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    r_dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_dig = a_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        b_dig = b_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        r_dig = result[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  always_comb begin
    ops_valid = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(a_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          !bcd_digit_valid(b_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        ops_valid = 1'b0;
    end
  end

  always_comb begin
    last    = (idx == IDX_W'(DIGITS - 1));
    comp_in = (state == RECOMP) ? r_dig : b_dig;
    add_x   = (state == RECOMP) ? '0 : a_dig;
  end

  Complement_9 u_comp (
    .digit (comp_in),
    .comp  (comp_out)
  );

  bcd_digit_adder u_add (
    .x     (add_x),
    .y     (comp_out),
    .cin   (carry),
    .digit (sum_dig),
    .cout  (sum_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ops_valid ? SUB : DONE;
      SUB:     if (last)  state_nx = sum_cout ? DONE : RECOMP;
      RECOMP:  if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      negative <= 1'b0;
      invalid  <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q      <= a_bcd;
          b_q      <= b_bcd;
          result   <= '0;
          negative <= 1'b0;
          invalid  <= !ops_valid;
          idx      <= '0;
          carry    <= 1'b1;
        end
        SUB, RECOMP: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) result[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= sum_dig;
          end
          if (last) begin
            idx   <= '0;
            carry <= 1'b1;
            if (state == SUB) negative <= !sum_cout;
          end else begin
            idx   <= idx + IDX_W'(1);
            carry <= sum_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_sequencer.sv
// Directed bench for bcd_sub_sequencer with an expected-result scoreboard.
module tb_bcd_sub_sequencer;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a_bcd, b_bcd, result;
  logic         busy, done, negative, invalid;

  typedef struct {
    logic [W-1:0] result;
    logic         negative;
    logic         invalid;
    int           latency;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  bcd_sub_sequencer #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_bcd    (a_bcd),
    .b_bcd    (b_bcd),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .negative (negative),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      v[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit bad = 1'b0;
    int ai, bi;
    for (int i = 0; i < DIGITS; i++)
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad = 1'b1;
    e.invalid  = bad;
    e.result   = '0;
    e.negative = 1'b0;
    e.latency  = 1;
    if (!bad) begin
      ai = bcd2int(a);
      bi = bcd2int(b);
      e.negative = (ai < bi);
      e.result   = int2bcd(ai < bi ? bi - ai : ai - bi);
      e.latency  = (ai < bi) ? 2 * DIGITS + 1 : DIGITS + 1;
    end
    return e;
  endfunction

  // Assumes we sit #1 after a clock edge; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    a_bcd = W'($urandom);
    b_bcd = W'($urandom);
  endtask

  task automatic wait_done(input string tag, input bit pulse);
    int   cyc = 1;
    int   extra = 0;
    exp_t e;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 60) begin
      if (pulse && (cyc == 2 || cyc == 6)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(cyc), 32'(e.latency));
    check({tag, "_res"}, 32'(result), 32'(e.result));
    check({tag, "_neg"}, 32'(negative), 32'(e.negative));
    check({tag, "_inv"}, 32'(invalid), 32'(e.invalid));
    @(posedge clk); #1;
    check({tag, "_pulse1"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(e.result));
    if (pulse) begin
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, "_nodup"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int dcount;
    rst   = 1'b1;
    start = 1'b0;
    a_bcd = '0;
    b_bcd = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_neg", 32'(negative), 32'd0);
    check("rst_inv", 32'(invalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(16'h0753, 16'h0248); wait_done("t1", 1'b0);
    issue(16'h0248, 16'h0753); wait_done("t2", 1'b0);
    issue(16'h1234, 16'h1234); wait_done("t3eq", 1'b0);
    issue(16'h0000, 16'h9999); wait_done("t3max", 1'b0);
    issue(16'h00A0, 16'h0001); wait_done("t4inv", 1'b0);
    issue(16'h0248, 16'h0753); wait_done("t5ign", 1'b1);

    // Reset mid-operation
    issue(16'h0248, 16'h0753);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_res", 32'(result), 32'd0);
    check("t6_neg", 32'(negative), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("t6_nodone", 32'(dcount), 32'd0);
    issue(16'h0248, 16'h0753); wait_done("t6_after", 1'b0);

    issue(16'h9999, 16'h0000); wait_done("edge_max", 1'b0);
    issue(16'h1000, 16'h0001); wait_done("edge_borrow", 1'b0);
    issue(16'h0001, 16'h1000); wait_done("edge_neg", 1'b0);
    issue(16'h1234, 16'hF000); wait_done("edge_invb", 1'b0);

    for (int n = 0; n < 6; n++) begin
      logic [W-1:0] ra, rb;
      ra = int2bcd(int'($urandom_range(9999, 0)));
      rb = int2bcd(int'($urandom_range(9999, 0)));
      issue(ra, rb);
      wait_done("rand", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
